qspi_rom_reader: RTL and testbench



---
 rtl/qspi_rom_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_qspi_rom_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rom_reader.sv
// qspi_rom_reader: quad-SPI byte read initiator for cartridge ROM fetches.
// Optional continuous-read mode: define QSPI_CONTINUOUS_EN.
`timescale 1ns/1ps
module qspi_rom_reader #(
   parameter int          ADDR_W       = 24,
   parameter logic [7:0]  CMD          = 8'hEB,
   parameter int          DUMMY_CYCLES = 4,
   parameter int          MIN_DESELECT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [7:0]        resp_data,
   output logic              qspi_sclk,
   output logic              qspi_select,
   output logic [3:0]        qspi_io_out,
   output logic              qspi_io_oe,
   input  logic [3:0]        qspi_io_in
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DUMMY = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_DESEL = 3'd6;
`ifdef QSPI_CONTINUOUS_EN
   localparam logic [2:0] S_HOLD  = 3'd7;
`endif

   // last SPI cycle index of the dummy phase, last clk of deselect
   localparam logic [4:0] DUMMY_LAST = 5'((DUMMY_CYCLES > 1) ? DUMMY_CYCLES - 1 : 0);
   localparam logic [4:0] DESEL_LAST = 5'((MIN_DESELECT > 1) ? MIN_DESELECT - 1 : 0);

   logic [2:0]  state;
   logic [4:0]  cnt;
   logic [31:0] tx;
   logic [7:0]  rx;
   logic [23:0] addr24;

   // address as it goes on the wire, zero-extended to 24 bits
   assign addr24 = 24'(req_addr);

`ifdef QSPI_CONTINUOUS_EN
   logic [ADDR_W-1:0] last_addr;
   logic              pending;
   logic              seq_hit;

   // the ROM streams the following byte if select stays low, wrapping
   assign seq_hit = (req_addr == last_addr + ADDR_W'(1));
`endif

   // transaction sequencer: one SPI cycle is a low clk then a high clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_DESEL;
         cnt         <= '0;
         tx          <= '0;
         rx          <= '0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         qspi_sclk   <= 1'b0;
         qspi_select <= 1'b1;
         qspi_io_out <= '0;
         qspi_io_oe  <= 1'b0;
`ifdef QSPI_CONTINUOUS_EN
         last_addr   <= '0;
         pending     <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               qspi_select <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready   <= 1'b0;
                  state       <= S_CMD;
                  cnt         <= '0;
                  qspi_select <= 1'b0;
                  qspi_sclk   <= 1'b0;
                  qspi_io_oe  <= 1'b1;
                  qspi_io_out <= CMD[7:4];
                  tx          <= {CMD[3:0], addr24, 4'h0};
`ifdef QSPI_CONTINUOUS_EN
                  last_addr   <= req_addr;
`endif
               end
            end
            S_CMD: begin
               if (!qspi_sclk) begin
                  qspi_sclk <= 1'b1;
               end else begin
                  qspi_sclk   <= 1'b0;
                  qspi_io_out <= tx[31:28];
                  tx          <= {tx[27:0], 4'h0};
                  if (cnt == 5'd1) begin
                     state <= S_ADDR;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            S_ADDR: begin
               if (!qspi_sclk) begin
                  qspi_sclk <= 1'b1;
               end else begin
                  qspi_sclk <= 1'b0;
                  if (cnt == 5'd5) begin
                     state       <= S_DUMMY;
                     cnt         <= '0;
                     qspi_io_oe  <= 1'b0;
                     qspi_io_out <= '0;
                  end else begin
                     cnt         <= cnt + 5'd1;
                     qspi_io_out <= tx[31:28];
                     tx          <= {tx[27:0], 4'h0};
                  end
               end
            end
            S_DUMMY: begin
               if (!qspi_sclk) begin
                  qspi_sclk <= 1'b1;
               end else begin
                  qspi_sclk <= 1'b0;
                  if (cnt == DUMMY_LAST) begin
                     state <= S_DATA;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            S_DATA: begin
               if (!qspi_sclk) begin
                  qspi_sclk <= 1'b1;
               end else begin
                  qspi_sclk <= 1'b0;
                  rx        <= {rx[3:0], qspi_io_in};
                  if (cnt == 5'd1) begin
                     state <= S_DONE;
                     cnt   <= '0;
`ifndef QSPI_CONTINUOUS_EN
                     qspi_select <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            S_DONE: begin
               resp_valid <= 1'b1;
               resp_data  <= rx;
               cnt        <= '0;
               qspi_sclk  <= 1'b0;
`ifdef QSPI_CONTINUOUS_EN
               state      <= S_HOLD;
               req_ready  <= 1'b1;
`else
               state      <= S_DESEL;
`endif
            end
            S_DESEL: begin
               qspi_select <= 1'b1;
               qspi_sclk   <= 1'b0;
               qspi_io_oe  <= 1'b0;
               qspi_io_out <= '0;
               if (cnt == DESEL_LAST) begin
                  cnt <= '0;
`ifdef QSPI_CONTINUOUS_EN
                  if (pending) begin
                     pending     <= 1'b0;
                     state       <= S_CMD;
                     qspi_select <= 1'b0;
                     qspi_io_oe  <= 1'b1;
                     qspi_io_out <= CMD[7:4];
                  end else begin
                     state     <= S_IDLE;
                     req_ready <= 1'b1;
                  end
`else
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
`ifdef QSPI_CONTINUOUS_EN
            S_HOLD: begin
               qspi_sclk <= 1'b0;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  last_addr <= req_addr;
                  cnt       <= '0;
                  if (seq_hit) begin
                     state <= S_DATA;
                  end else begin
                     pending     <= 1'b1;
                     state       <= S_DESEL;
                     qspi_select <= 1'b1;
                     tx          <= {CMD[3:0], addr24, 4'h0};
                  end
               end
            end
`endif
            default: begin
               state       <= S_DESEL;
               cnt         <= '0;
               req_ready   <= 1'b0;
               qspi_select <= 1'b1;
               qspi_sclk   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_rom_reader.sv
// tb_qspi_rom_reader: emulated QSPI ROM plus response scoreboard.
// Build with QSPI_CONTINUOUS_EN defined to cover continuous-read mode.
`timescale 1ns/1ps
module tb_qspi_rom_reader;

   localparam int DUMMY    = 4;
   localparam int MIND     = 2;
   localparam int LAT_FULL = 2 * (2 + 6 + DUMMY + 2) + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [23:0] req_addr = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic        qspi_sclk;
   logic        qspi_select;
   logic [3:0]  qspi_io_out;
   logic        qspi_io_oe;
   logic [3:0]  qspi_io_in = 4'h0;

   qspi_rom_reader #(
      .ADDR_W(24), .CMD(8'hEB),
      .DUMMY_CYCLES(DUMMY), .MIN_DESELECT(MIND)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .qspi_sclk(qspi_sclk), .qspi_select(qspi_select),
      .qspi_io_out(qspi_io_out), .qspi_io_oe(qspi_io_oe),
      .qspi_io_in(qspi_io_in)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)",
                  name, act, req, $time);
      end
   endtask

   // ROM contents seen by both the emulated device and the model
   function automatic logic [7:0] rom(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h83;
   endfunction

   // ---------------- emulated ROM ----------------
   int          k = 0;
   int          j = 0;
   int          spi_rises = 0;
   int          sel_rises = 0;
   logic [31:0] hdr = '0;
   logic [23:0] base = '0;
   logic [7:0]  b = '0;

   always @(posedge qspi_select) begin
      k = 0;
      sel_rises++;
   end

   always @(posedge qspi_sclk) begin
      spi_rises++;
      if (!qspi_select) begin
         if (k < 8) begin
            chk("oe_hdr", {31'd0, qspi_io_oe}, 32'd1);
            hdr = {hdr[27:0], qspi_io_out};
            if (k == 7) begin
               base = hdr[23:0];
               chk("cmd_byte", {24'd0, hdr[31:24]}, 32'hEB);
            end
            qspi_io_in = 4'h9;
         end else if (k < 8 + DUMMY) begin
            chk("oe_dummy", {31'd0, qspi_io_oe}, 32'd0);
            qspi_io_in = 4'h9;
         end else begin
            chk("oe_data", {31'd0, qspi_io_oe}, 32'd0);
            j = k - 8 - DUMMY;
            b = rom(base + 24'(j / 2));
            qspi_io_in = (j % 2 == 0) ? b[7:4] : b[3:0];
         end
         k++;
      end
   end

   // ---------------- response model ----------------
   typedef struct {
      int          due;
      logic [23:0] addr;
   } exp_t;

   exp_t        sbq[$];
   int          acc_edges[$];
   int          resp_edges[$];
   int          edge_n = 0;
   int          n_acc = 0;
   int          n_resp = 0;
   int          dut_pulses = 0;
   int          lat = 0;
   bit          held = 0;
   bit          expv = 0;
   logic [23:0] last_a = '0;
   logic [7:0]  hold_exp = '0;
   logic [7:0]  got_data = '0;

   // log accepted requests and when their byte is due
   always @(posedge clk) begin
      edge_n++;
      if (rst_n && req_valid && req_ready) begin
`ifdef QSPI_CONTINUOUS_EN
         if (held && req_addr == last_a + 24'd1) lat = 5;
         else if (held) lat = LAT_FULL + MIND;
         else lat = LAT_FULL;
`else
         lat = LAT_FULL;
`endif
         sbq.push_back('{edge_n + lat, req_addr});
         acc_edges.push_back(edge_n);
         last_a = req_addr;
         n_acc++;
      end
   end

   always @(negedge rst_n) begin
      sbq.delete();
      held = 0;
      hold_exp = '0;
   end

   logic prev_sel = 1'b1;
   int   low_run = 0;
   int   last_low_run = 0;
   int   high_run = 0;
   int   last_high_run = 0;

   // per-cycle compare of responses and pin protocol
   always @(negedge clk) begin
      if (resp_valid) dut_pulses++;
      if (rst_n) begin
         expv = (sbq.size() > 0) && (sbq[0].due == edge_n);
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, expv});
         if (expv) begin
            hold_exp = rom(sbq[0].addr);
            chk("resp_data", {24'd0, resp_data}, {24'd0, hold_exp});
            got_data = resp_data;
            resp_edges.push_back(edge_n);
            n_resp++;
            sbq.pop_front();
`ifdef QSPI_CONTINUOUS_EN
            held = 1;
`endif
         end else begin
            chk("resp_hold", {24'd0, resp_data}, {24'd0, hold_exp});
         end
         chk("sclk_desel", {31'd0, qspi_sclk & qspi_select}, 32'd0);
         chk("sel_vs_sclk",
             {31'd0, (qspi_select != prev_sel) & qspi_sclk}, 32'd0);
      end
      if (!qspi_select) begin
         if (prev_sel) last_high_run = high_run;
         low_run++;
         high_run = 0;
      end else begin
         if (!prev_sel) last_low_run = low_run;
         high_run++;
         low_run = 0;
      end
      prev_sel = qspi_select;
   end

   // ---------------- stimulus ----------------
   task automatic wait_acc(input int target);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (n_acc >= target) begin
            ok = 1;
            break;
         end
      end
      chk("accept_in_time", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_req(input logic [23:0] a);
      int n0;
      n0 = n_acc;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      wait_acc(n0 + 1);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int target);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (n_resp >= target) begin
            ok = 1;
            break;
         end
      end
      chk("resp_in_time", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   int r0, a0, p0, s0, k0;

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk("rst_select", {31'd0, qspi_select}, 32'd1);
      chk("rst_sclk", {31'd0, qspi_sclk}, 32'd0);
      chk("rst_oe", {31'd0, qspi_io_oe}, 32'd0);
      chk("rst_io_out", {28'd0, qspi_io_out}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_deselect", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("ready_after_desel", {31'd0, req_ready}, 32'd1);

      // single read, pinned values
      chk("model_rom", {24'd0, rom(24'h001234)}, 32'hA5);
      r0 = n_resp;
      do_req(24'h001234);
      wait_resp(r0 + 1);
      chk("t1_latency", resp_edges[$] - acc_edges[$], 29);
      chk("t1_data", {24'd0, got_data}, 32'hA5);
      chk("t1_nibbles", hdr, 32'hEB001234);
`ifndef QSPI_CONTINUOUS_EN
      chk("t1_sel_low", last_low_run, 28);
`endif

      // back-to-back with req_valid held
      r0 = n_resp;
      a0 = n_acc;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 24'h000100;
      wait_acc(a0 + 1);
      req_addr  = 24'h00ABCD;
      wait_acc(a0 + 2);
      req_valid = 1'b0;
      wait_resp(r0 + 2);
`ifndef QSPI_CONTINUOUS_EN
      chk("t2_gap",
          {31'd0, (acc_edges[$] - resp_edges[resp_edges.size() - 2]) >= MIND},
          32'd1);
      chk("t2_sel_high", {31'd0, last_high_run >= MIND}, 32'd1);
`endif

      // reset during address nibble 3
      r0 = n_resp;
      do_req(24'h00C3DE);
      repeat (10) @(posedge clk);
      #1;
      chk("t3_addr_nib3", {28'd0, qspi_io_out}, 32'h3);
      chk("t3_sel_before", {31'd0, qspi_select}, 32'd0);
      p0 = dut_pulses;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t3_async_sel", {31'd0, qspi_select}, 32'd1);
      chk("t3_async_sclk", {31'd0, qspi_sclk}, 32'd0);
      chk("t3_async_oe", {31'd0, qspi_io_oe}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("t3_no_resp", dut_pulses - p0, 0);
      r0 = n_resp;
      do_req(24'h00BEEF);
      wait_resp(r0 + 1);
      chk("t3_data", {24'd0, got_data}, 32'hD2);

      // req_valid toggling while busy
      r0 = n_resp;
      p0 = dut_pulses;
      do_req(24'h000777);
      a0 = n_acc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         req_valid = ~req_valid;
         req_addr  = 24'h000900 + 24'(i);
      end
      req_valid = 1'b0;
      chk("t4_no_accept", n_acc - a0, 0);
      wait_resp(r0 + 1);
      repeat (10) @(negedge clk);
      chk("t4_one_pulse", dut_pulses - p0, 1);
      chk("t4_data", {24'd0, got_data}, 32'hF3);

`ifdef QSPI_CONTINUOUS_EN
      // sequential read across the address wrap
      r0 = n_resp;
      do_req(24'hFFFFFF);
      wait_resp(r0 + 1);
      chk("t5_first", {24'd0, got_data}, 32'h7C);
      s0 = sel_rises;
      k0 = spi_rises;
      do_req(24'h000000);
      wait_resp(r0 + 2);
      chk("t5_latency", resp_edges[$] - acc_edges[$], 5);
      chk("t5_data", {24'd0, got_data}, 32'h83);
      chk("t5_sel_stays", sel_rises - s0, 0);
      chk("t5_spi_cycles", spi_rises - k0, 2);

      // non-sequential read from hold
      r0 = n_resp;
      do_req(24'h000010);
      wait_resp(r0 + 1);
      s0 = sel_rises;
      k0 = spi_rises;
      do_req(24'h000020);
      wait_resp(r0 + 2);
      chk("t6_data", {24'd0, got_data}, 32'hA3);
      chk("t6_sel_high", {31'd0, last_high_run >= 2}, 32'd1);
      chk("t6_sel_rise", sel_rises - s0, 1);
      chk("t6_spi_cycles", spi_rises - k0, 14);
`endif

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
